wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order WB stage and the out-of-order multiply/divide unit (MDU).
- The WB stage has priority. MDU results wait in a small queue and drain into free write-port cycles.
- When MDU results are starved, the block stalls the pipeline for one cycle to drain the queue.
- Queued entries made stale by a pipeline write to the same rd are killed.

Parameters:
- DEPTH, 2, number of MDU result-queue entries (any value >= 1; need not be a power of two).
- STARVE_MAX, 4, number of consecutive ungranted cycles with the queue non-empty before the pipeline is stalled.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pipe_valid  in  1  WB stage holds a ready, valid instruction (mem_wb_rdy && mem_wb_valid).
- pipe_ld_reg  in  1  WB stage wants to write (load_reg).
- pipe_rd  in  5  WB destination register.
- pipe_data  in  32  WB write data (regfilemux_out).
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  32  MDU result.
- mdu_ready  out  1  queue accepts an MDU result this cycle.
- pipe_stall  out  1  hold the WB stage this cycle; its write is not performed.
- regfile_ld  out  1  register-file write enable.
- regfile_rd  out  5  register-file write address.
- regfile_in  out  32  register-file write data.
- grant_mdu  out  1  the current write-port cycle belongs to the queue head.
- q_count  out  $clog2(DEPTH+1)  occupancy of the queue.

Behaviour:
- Reset (rst = 0, asynchronous):
  - Queue pointers, q_count, starvation counter and all kill bits clear to 0.
  - While rst = 0, all outputs are forced to 0: mdu_ready, pipe_stall, regfile_ld, regfile_rd, regfile_in and grant_mdu.
  - Reset arriving mid-drain discards all queued results without writing them.
- Enqueue:
  - mdu_ready = (q_count < DEPTH). It is not made combinationally dependent on a same-cycle dequeue.
  - A result is accepted when mdu_valid && mdu_ready.
  - If mdu_rd = 0, the handshake completes but nothing is stored.
  - Otherwise {rd, data, kill = 0} is written at the tail. The tail advances and wraps from DEPTH-1 to 0.
- Pipeline write request: pipe_wr = pipe_valid && pipe_ld_reg && (pipe_rd != 0).
- Starvation counter (starve_cnt):
  - Counts cycles with the queue non-empty and grant_mdu = 0.
  - Clears when grant_mdu = 1 or when the queue is empty.
  - Saturates at STARVE_MAX.
- Grant (combinational, same cycle):
  - The queue is non-empty and (pipe_wr = 0 or starve_cnt = STARVE_MAX): grant_mdu = 1, and pipe_stall = pipe_wr.
  - Otherwise: grant_mdu = 0, and the pipeline owns the port.
- Write port:
  - grant_mdu = 1: regfile_rd = head.rd, regfile_in = head.data, regfile_ld = !head.kill. The head is popped that cycle.
  - Pipeline owns the port: regfile_ld = pipe_wr, regfile_rd = pipe_rd, regfile_in = pipe_data.
  - regfile_ld is never 1 with regfile_rd = 0.
- Kill (WAW):
  - On any cycle where the pipeline write is performed (pipe_wr && !pipe_stall), every valid queued entry with rd == pipe_rd sets kill = 1 on the next edge. The younger pipeline value wins.
  - An entry enqueued in the same cycle is not killed.
  - A killed entry still occupies its slot, drains in order and consumes a grant, but regfile_ld = 0 for it.
- Simultaneous enqueue and dequeue:
  - q_count is unchanged and both pointers advance.
  - The case of full and draining still holds mdu_ready = 0 that cycle.
- Latency:
  - A result enqueued at edge N is eligible for grant in cycle N+1.
  - The worst case from enqueue to write, with the pipeline writing every cycle, is DEPTH*(STARVE_MAX+1) cycles.
- pipe_stall is asserted for at most one cycle per starvation event, because the counter clears on the grant.

Decomposition:
- The following go in package cpuIO:
  - typedef wbarb_entry_t {rv32i_reg rd; rv32i_word data; logic kill;}.
  - localparam WBARB_DEPTH_DEFAULT = 2.
- One sub-module, wb_result_fifo:
  - Implements the circular queue, head/tail, q_count and the per-entry rd compare with kill-set.
  - Exposes push, pop, kill_en, kill_rd and head.
- wb_port_arbiter holds the starvation counter, grant logic and write-port mux.

Test Plan:
- Reset: drive rst = 0 with mdu_valid = 1 and rd = 5 -> mdu_ready = 0, regfile_ld = 0, q_count = 0. Release rst -> mdu_ready = 1 next cycle.
- Idle drain: pipe_valid = 0, MDU pushes rd = 7, data = 0x0000_002A -> next cycle grant_mdu = 1, regfile_ld = 1, regfile_rd = 7, regfile_in = 0x2A, q_count returns to 0.
- Priority and starvation: pipe writes rd = 1 every cycle, MDU pushes rd = 9 once -> the pipe wins for 4 cycles, then pipe_stall = 1 and grant_mdu = 1 writing rd = 9 on the 5th cycle. On the 6th cycle the pipe resumes and pipe_stall = 0.
- Full queue: with DEPTH = 2, push two MDU results while the pipe writes continuously -> q_count = 2, mdu_ready = 0. The third result is held until the first drain edge.
- Kill: queue holds rd = 3 with data 0x11, then the pipe writes rd = 3 with data 0x22 -> on drain, grant_mdu = 1 and regfile_ld = 0. The final value of x3 is 0x22.
- rd = 0 and wrap-around: an MDU push with rd = 0 leaves q_count = 0. Push/pop 5 alternating results through DEPTH = 2 -> the written rd order matches the push order across pointer wrap.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// The MDU result queue stores one wbarb_entry_t per slot.
package cpuIO;

    typedef logic [4:0]  rv32i_reg;
    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_reg  rd;
        rv32i_word data;
        logic      kill;
    } wbarb_entry_t;

    localparam int unsigned WBARB_DEPTH_DEFAULT      = 2;
    localparam int unsigned WBARB_STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of WB-stage, MDU and register-file write-port signals seen by the arbiter.
// slave = arbiter side, master = pipeline/MDU/regfile side.
interface wb_port_arbiter_if #(
    parameter int unsigned DEPTH = 2
);
    import cpuIO::*;

    logic                         pipe_valid;
    logic                         pipe_ld_reg;
    rv32i_reg                     pipe_rd;
    rv32i_word                    pipe_data;
    logic                         mdu_valid;
    rv32i_reg                     mdu_rd;
    rv32i_word                    mdu_data;
    logic                         mdu_ready;
    logic                         pipe_stall;
    logic                         regfile_ld;
    rv32i_reg                     regfile_rd;
    rv32i_word                    regfile_in;
    logic                         grant_mdu;
    logic [$clog2(DEPTH+1)-1:0]   q_count;

    modport slave (
        input  pipe_valid, pipe_ld_reg, pipe_rd, pipe_data,
        input  mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, pipe_stall, regfile_ld, regfile_rd, regfile_in, grant_mdu, q_count
    );

    modport master (
        output pipe_valid, pipe_ld_reg, pipe_rd, pipe_data,
        output mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, pipe_stall, regfile_ld, regfile_rd, regfile_in, grant_mdu, q_count
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Circular queue of pending MDU results with per-entry WAW kill marking.
// Any occupied slot whose rd matches kill_rd_i gets its kill bit set on the next edge.
module wb_result_fifo
    import cpuIO::*;
#(
    parameter int unsigned DEPTH = WBARB_DEPTH_DEFAULT,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  wbarb_entry_t    push_entry_i,
    input  logic            pop_i,
    input  logic            kill_en_i,
    input  rv32i_reg        kill_rd_i,
    output wbarb_entry_t    head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    wbarb_entry_t    mem_q [DEPTH];
    wbarb_entry_t    mem_d [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        int unsigned off;
        off     = 0;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Offset from head tells whether slot i currently holds a live entry.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = (i >= 32'(head_q)) ? i - 32'(head_q) : i + DEPTH - 32'(head_q);
            if (kill_en_i && (off < 32'(count_q)) && (mem_q[i].rd == kill_rd_i)) begin
                mem_d[i].kill = 1'b1;
            end
        end
        if (pop_i) begin
            head_d = ptr_inc(head_q);
        end
        if (push_i) begin
            mem_d[tail_q] = push_entry_i;
            tail_d        = ptr_inc(tail_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and queued MDU results.
// WB has priority; a starved queue steals one cycle by stalling the pipeline.
module wb_port_arbiter
    import cpuIO::*;
#(
    parameter int unsigned DEPTH      = WBARB_DEPTH_DEFAULT,
    parameter int unsigned STARVE_MAX = WBARB_STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SW   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    wbarb_entry_t    head, push_entry;
    logic            empty, full, push, pop, kill_en, pipe_wr, grant;
    logic [CntW-1:0] count;
    logic [SW-1:0]   starve_q, starve_d;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_en_i    (kill_en),
        .kill_rd_i    (bus.pipe_rd),
        .head_o       (head),
        .count_o      (count),
        .empty_o      (empty),
        .full_o       (full)
    );

    always_comb begin
        pipe_wr    = bus.pipe_valid && bus.pipe_ld_reg && (bus.pipe_rd != '0);
        grant      = rst && !empty && (!pipe_wr || (starve_q == SW'(STARVE_MAX)));
        push       = rst && bus.mdu_valid && !full && (bus.mdu_rd != '0);
        push_entry = '{rd: bus.mdu_rd, data: bus.mdu_data, kill: 1'b0};
        pop        = grant;
        // Only a performed pipeline write makes queued results stale.
        kill_en    = rst && pipe_wr && !grant;

        starve_d = starve_q;
        if (empty || grant) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        bus.mdu_ready  = rst && !full;
        bus.pipe_stall = grant && pipe_wr;
        bus.grant_mdu  = grant;
        bus.q_count    = rst ? count : '0;
        bus.regfile_ld = 1'b0;
        bus.regfile_rd = '0;
        bus.regfile_in = '0;
        if (grant) begin
            bus.regfile_ld = !head.kill;
            bus.regfile_rd = head.rd;
            bus.regfile_in = head.data;
        end else if (rst) begin
            bus.regfile_ld = pipe_wr;
            bus.regfile_rd = bus.pipe_rd;
            bus.regfile_in = bus.pipe_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model of the arbitration rules.
module tb_wb_port_arbiter;
    import cpuIO::*;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } ment_t;

    ment_t       mq[$];
    int          starve;
    logic [31:0] dut_rf [32];
    logic        exp_ready, exp_stall, exp_ld, exp_grant;
    logic [4:0]  exp_rd;
    logic [31:0] exp_in;
    int          exp_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: expected outputs for the current inputs and queue contents.
    task automatic model_eval();
        bit pw;
        pw = bus.pipe_valid && bus.pipe_ld_reg && (bus.pipe_rd != 5'd0);
        exp_ready = 0; exp_stall = 0; exp_ld = 0; exp_grant = 0;
        exp_rd = 0; exp_in = 0; exp_cnt = 0;
        if (!rst) return;
        exp_cnt   = mq.size();
        exp_ready = (mq.size() < DEPTH);
        exp_grant = (mq.size() > 0) && (!pw || starve == STARVE_MAX);
        exp_stall = exp_grant && pw;
        if (exp_grant) begin
            exp_ld = !mq[0].kill; exp_rd = mq[0].rd; exp_in = mq[0].data;
        end else begin
            exp_ld = pw; exp_rd = bus.pipe_rd; exp_in = bus.pipe_data;
        end
    endtask

    task automatic model_commit();
        bit pw;
        if (!rst) begin
            mq.delete(); starve = 0; return;
        end
        pw = bus.pipe_valid && bus.pipe_ld_reg && (bus.pipe_rd != 5'd0);
        if (pw && !exp_stall)
            foreach (mq[i]) if (mq[i].rd == bus.pipe_rd) mq[i].kill = 1;
        if (mq.size() == 0 || exp_grant) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        if (exp_grant) void'(mq.pop_front());
        if (bus.mdu_valid && exp_ready && bus.mdu_rd != 5'd0)
            mq.push_back('{rd: bus.mdu_rd, data: bus.mdu_data, kill: 0});
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        #1;
        model_eval();
        if (bus.regfile_ld === 1'b1) dut_rf[bus.regfile_rd] = bus.regfile_in;
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.pipe_valid = 0; bus.pipe_ld_reg = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
        bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_valid = v; bus.pipe_ld_reg = v; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mdu_valid = v; bus.mdu_rd = rd; bus.mdu_data = d;
    endtask

    task automatic test_reset();
        set_idle();
        set_mdu(1, 5'd5, 32'h1234);
        rst = 0;
        settle();
        n_checks++; if (bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset mdu_ready: got %b want 0", bus.mdu_ready); end
        n_checks++; if (bus.regfile_ld !== 1'b0) begin n_fail++; $display("FAIL reset regfile_ld: got %b want 0", bus.regfile_ld); end
        n_checks++; if (bus.grant_mdu !== 1'b0 || bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset grant/stall: got %b/%b want 0/0", bus.grant_mdu, bus.pipe_stall); end
        advance();
        n_checks++; if (bus.q_count !== 0) begin n_fail++; $display("FAIL reset q_count: got %0d want 0", bus.q_count); end
        set_idle();
        rst = 1;
        settle();
        n_checks++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset release mdu_ready: got %b want 1", bus.mdu_ready); end
        advance();
    endtask

    task automatic test_idle_drain();
        set_idle();
        set_mdu(1, 5'd7, 32'h0000_002A);
        advance();
        set_idle();
        settle();
        n_checks++; if (bus.grant_mdu !== 1'b1 || bus.regfile_ld !== 1'b1) begin n_fail++; $display("FAIL idle grant/ld: got %b/%b want 1/1", bus.grant_mdu, bus.regfile_ld); end
        n_checks++; if (bus.regfile_rd !== 5'd7 || bus.regfile_in !== 32'h2A) begin n_fail++; $display("FAIL idle write: got rd %0d data %h want rd 7 data 2a", bus.regfile_rd, bus.regfile_in); end
        advance();
        settle();
        n_checks++; if (bus.q_count !== 0 || bus.grant_mdu !== 1'b0) begin n_fail++; $display("FAIL idle after: got q %0d grant %b want 0/0", bus.q_count, bus.grant_mdu); end
        advance();
    endtask

    task automatic test_starvation();
        set_idle();
        set_pipe(1, 5'd1, $urandom);
        set_mdu(1, 5'd9, 32'h99);
        advance();
        set_mdu(0, 5'd0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1, 5'd1, $urandom);
            settle();
            n_checks++; if (bus.grant_mdu !== 1'b0 || bus.pipe_stall !== 1'b0 || bus.regfile_rd !== 5'd1) begin n_fail++; $display("FAIL starve pipe wins cycle %0d: got grant %b stall %b rd %0d want 0 0 1", k, bus.grant_mdu, bus.pipe_stall, bus.regfile_rd); end
            advance();
        end
        set_pipe(1, 5'd1, $urandom);
        settle();
        n_checks++; if (bus.pipe_stall !== 1'b1 || bus.grant_mdu !== 1'b1 || bus.regfile_rd !== 5'd9) begin n_fail++; $display("FAIL starve steal: got stall %b grant %b rd %0d want 1 1 9", bus.pipe_stall, bus.grant_mdu, bus.regfile_rd); end
        advance();
        settle();
        n_checks++; if (bus.pipe_stall !== 1'b0 || bus.grant_mdu !== 1'b0 || bus.regfile_ld !== 1'b1 || bus.regfile_rd !== 5'd1) begin n_fail++; $display("FAIL starve resume: got stall %b grant %b ld %b rd %0d want 0 0 1 1", bus.pipe_stall, bus.grant_mdu, bus.regfile_ld, bus.regfile_rd); end
        advance();
        set_idle();
        advance();
    endtask

    task automatic test_full();
        int grant_idx = -1;
        int accept_idx = -1;
        set_idle();
        set_pipe(1, 5'd1, 32'h1);
        set_mdu(1, 5'd10, 32'hA0);
        advance();
        set_mdu(1, 5'd11, 32'hB0);
        advance();
        set_mdu(1, 5'd12, 32'hC0);
        settle();
        n_checks++; if (bus.q_count !== 2 || bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL full: got q %0d ready %b want 2 0", bus.q_count, bus.mdu_ready); end
        for (int i = 0; i < 20 && accept_idx < 0; i++) begin
            settle();
            n_checks++; if (bus.mdu_ready !== exp_ready || bus.grant_mdu !== exp_grant) begin n_fail++; $display("FAIL full hold cycle %0d: got ready %b grant %b want %b %b", i, bus.mdu_ready, bus.grant_mdu, exp_ready, exp_grant); end
            if (bus.grant_mdu === 1'b1 && grant_idx < 0) grant_idx = i;
            if (bus.mdu_ready === 1'b1) accept_idx = i;
            advance();
        end
        n_checks++; if (grant_idx != 3 || accept_idx != 4) begin n_fail++; $display("FAIL full timing: got grant %0d accept %0d want 3 4", grant_idx, accept_idx); end
        set_idle();
        for (int i = 0; i < 10 && mq.size() > 0; i++) advance();
        settle();
        n_checks++; if (bus.q_count !== 0) begin n_fail++; $display("FAIL full drain q_count: got %0d want 0", bus.q_count); end
    endtask

    task automatic test_kill();
        set_idle();
        set_mdu(1, 5'd3, 32'h11);
        advance();
        set_idle();
        set_pipe(1, 5'd3, 32'h22);
        settle();
        n_checks++; if (bus.grant_mdu !== 1'b0 || bus.regfile_in !== 32'h22) begin n_fail++; $display("FAIL kill pipe write: got grant %b data %h want 0 22", bus.grant_mdu, bus.regfile_in); end
        advance();
        set_idle();
        settle();
        n_checks++; if (bus.grant_mdu !== 1'b1 || bus.regfile_ld !== 1'b0) begin n_fail++; $display("FAIL kill drain: got grant %b ld %b want 1 0", bus.grant_mdu, bus.regfile_ld); end
        advance();
        n_checks++; if (dut_rf[3] !== 32'h22) begin n_fail++; $display("FAIL kill x3: got %h want 22", dut_rf[3]); end
        // Same-cycle enqueue is older than nothing: the queued value must survive.
        set_mdu(1, 5'd4, 32'h33);
        set_pipe(1, 5'd4, 32'h44);
        advance();
        set_idle();
        settle();
        n_checks++; if (bus.grant_mdu !== 1'b1 || bus.regfile_ld !== 1'b1 || bus.regfile_in !== 32'h33) begin n_fail++; $display("FAIL kill same-cycle: got grant %b ld %b data %h want 1 1 33", bus.grant_mdu, bus.regfile_ld, bus.regfile_in); end
        advance();
        n_checks++; if (dut_rf[4] !== 32'h33) begin n_fail++; $display("FAIL kill x4: got %h want 33", dut_rf[4]); end
    endtask

    task automatic test_rd0_wrap();
        logic [4:0] order[$];
        set_idle();
        set_mdu(1, 5'd0, 32'hDEAD);
        settle();
        n_checks++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0 ready: got %b want 1", bus.mdu_ready); end
        advance();
        set_idle();
        settle();
        n_checks++; if (bus.q_count !== 0 || bus.grant_mdu !== 1'b0) begin n_fail++; $display("FAIL rd0 stored: got q %0d grant %b want 0 0", bus.q_count, bus.grant_mdu); end
        for (int i = 0; i < 5; i++) begin
            order.push_back(5'(20 + i));
            set_mdu(1, 5'(20 + i), $urandom);
            advance();
            set_idle();
            settle();
            n_checks++; if (bus.grant_mdu !== 1'b1 || bus.regfile_rd !== order[i]) begin n_fail++; $display("FAIL wrap order %0d: got grant %b rd %0d want 1 %0d", i, bus.grant_mdu, bus.regfile_rd, order[i]); end
            advance();
        end
    endtask

    task automatic test_reset_mid_drain();
        set_idle();
        set_pipe(1, 5'd2, 32'h5);
        set_mdu(1, 5'd13, 32'hD0);
        advance();
        set_mdu(1, 5'd14, 32'hE0);
        advance();
        set_idle();
        #2 rst = 0;
        #1;
        mq.delete(); starve = 0;
        n_checks++; if (bus.q_count !== 0 || bus.regfile_ld !== 1'b0 || bus.grant_mdu !== 1'b0 || bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL mid-drain reset: got q %0d ld %b grant %b ready %b want 0 0 0 0", bus.q_count, bus.regfile_ld, bus.grant_mdu, bus.mdu_ready); end
        @(negedge clk);
        rst = 1;
        settle();
        n_checks++; if (bus.q_count !== 0 || bus.grant_mdu !== 1'b0 || bus.regfile_ld !== 1'b0) begin n_fail++; $display("FAIL mid-drain after: got q %0d grant %b ld %b want 0 0 0", bus.q_count, bus.grant_mdu, bus.regfile_ld); end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.pipe_valid  = ($urandom_range(0, 3) != 0);
            bus.pipe_ld_reg = ($urandom_range(0, 3) != 0);
            bus.pipe_rd     = 5'($urandom_range(0, 7));
            bus.pipe_data   = $urandom;
            bus.mdu_valid   = ($urandom_range(0, 2) == 0);
            bus.mdu_rd      = 5'($urandom_range(0, 7));
            bus.mdu_data    = $urandom;
            settle();
            n_checks++; if (bus.mdu_ready !== exp_ready || bus.q_count !== exp_cnt) begin n_fail++; $display("FAIL rand %0d ready/q: got %b/%0d want %b/%0d", c, bus.mdu_ready, bus.q_count, exp_ready, exp_cnt); end
            n_checks++; if (bus.grant_mdu !== exp_grant || bus.pipe_stall !== exp_stall) begin n_fail++; $display("FAIL rand %0d grant/stall: got %b/%b want %b/%b", c, bus.grant_mdu, bus.pipe_stall, exp_grant, exp_stall); end
            n_checks++; if (bus.regfile_ld !== exp_ld || (exp_ld && (bus.regfile_rd !== exp_rd || bus.regfile_in !== exp_in))) begin n_fail++; $display("FAIL rand %0d write: got ld %b rd %0d data %h want ld %b rd %0d data %h", c, bus.regfile_ld, bus.regfile_rd, bus.regfile_in, exp_ld, exp_rd, exp_in); end
            advance();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        starve = 0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_idle_drain();
        test_starvation();
        test_full();
        test_kill();
        test_rd0_wrap();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
